// File: rtl/mdu_ctrl.sv
// mdu_ctrl: issue/sequencing control for the multiply/divide unit.
// Tracks one in-flight mult/div through IDLE -> RUN -> COMMIT, decodes
// mthi/mtlo writes, generates D-stage stall and flags illegal overlap.
// Optional build macro MDU_IRQ_ABORT_EN: an interrupt during RUN abandons
// the operation and pulses mdu_abort; without it interrupts in RUN are ignored.
module mdu_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [3:0] e_op,
  input  logic       d_md_use,
  input  logic       intreq,
  input  logic       eretop,
  output logic       mdu_start,
  output logic [3:0] mdu_op,
  output logic [1:0] hilo_we,
  output logic       busy,
  output logic       stall,
  output logic       done,
  output logic       mdu_abort,
  output logic       proto_err
);

  localparam int unsigned CW = 5;
  localparam logic [3:0] OP_NONE = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIVU = 4'd3;
  localparam logic [3:0] OP_MTHI = 4'd4;
  localparam logic [3:0] OP_MTLO = 4'd5;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYC - 2);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYC - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic proto_err_nxt;
  logic issue;
  logic accept;

  // State, counter and sticky protocol-error registers
  always_ff @(posedge clk) begin
    state     <= state_nxt;
    cnt       <= cnt_nxt;
    proto_err <= proto_err_nxt;
  end

  // Next-state decode and per-cycle control strobes; reset overrides everything
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    proto_err_nxt = proto_err;
    issue         = 1'b0;
    mdu_start     = 1'b0;
    mdu_op        = OP_NONE;
    hilo_we       = 2'b00;
    done          = 1'b0;
    mdu_abort     = 1'b0;
    accept        = e_valid & ~intreq & ~eretop;

    case (state)
      IDLE: begin
        if (accept && (e_op <= OP_DIVU)) begin
          issue     = 1'b1;
          mdu_start = 1'b1;
          mdu_op    = e_op;
          state_nxt = RUN;
          cnt_nxt   = (e_op <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
        end else if (accept && (e_op == OP_MTHI)) begin
          hilo_we = 2'b10;
          mdu_op  = e_op;
        end else if (accept && (e_op == OP_MTLO)) begin
          hilo_we = 2'b01;
          mdu_op  = e_op;
        end
      end
      RUN: begin
`ifdef MDU_IRQ_ABORT_EN
        if (intreq) begin
          mdu_abort = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = COMMIT;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
`else
        if (cnt == '0) begin
          state_nxt = COMMIT;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
`endif
      end
      COMMIT: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Any MDU write op arriving while an operation is in flight is dropped
    if ((state != IDLE) && e_valid && (e_op <= OP_MTLO)) begin
      proto_err_nxt = 1'b1;
    end

    if (reset) begin
      state_nxt     = IDLE;
      cnt_nxt       = '0;
      proto_err_nxt = 1'b0;
      issue         = 1'b0;
      mdu_start     = 1'b0;
      mdu_op        = OP_NONE;
      hilo_we       = 2'b00;
      done          = 1'b0;
      mdu_abort     = 1'b0;
    end
  end

  // Occupancy and D-stage hold
  assign busy  = (state != IDLE);
  assign stall = d_md_use & (busy | issue);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl. A timeline model (issue time,
// completion time) predicts every cycle's outputs; a monitor compares them.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       e_valid = 1'b0;
  logic [3:0] e_op = 4'd8;
  logic       d_md_use = 1'b0;
  logic       intreq = 1'b0;
  logic       eretop = 1'b0;
  logic       mdu_start;
  logic [3:0] mdu_op;
  logic [1:0] hilo_we;
  logic       busy, stall, done, mdu_abort, proto_err;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op),
    .d_md_use(d_md_use), .intreq(intreq), .eretop(eretop),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .hilo_we(hilo_we),
    .busy(busy), .stall(stall), .done(done), .mdu_abort(mdu_abort),
    .proto_err(proto_err)
  );

  logic [12:0] expq[$];
  int          cycq[$];
  int          vecs = 0;
  int          errs = 0;
  int          cyc = 0;

  // Reference model: an op issued at cycle t occupies t+1..t+L, done at t+L
  bit m_act = 1'b0;
  int m_done_at = 0;
  bit m_perr = 1'b0;

  task automatic step(input bit r, input bit v, input logic [3:0] op,
                      input bit d, input bit irq, input bit er);
    bit issue_e, done_e, abort_e, busy_e, stall_e;
    logic [1:0] hw;
    logic [3:0] mop;
    @(posedge clk);
    #1;
    reset = r; e_valid = v; e_op = op; d_md_use = d; intreq = irq; eretop = er;
    busy_e = m_act; issue_e = 1'b0; hw = 2'b00; mop = 4'd8;
    done_e = 1'b0; abort_e = 1'b0;
    if (!r) begin
      done_e = m_act && (cyc == m_done_at);
`ifdef MDU_IRQ_ABORT_EN
      abort_e = m_act && (cyc < m_done_at) && irq;
`endif
      if (!m_act && v && !irq && !er) begin
        if (op <= 4'd3) begin issue_e = 1'b1; mop = op; end
        else if (op == 4'd4) begin hw = 2'b10; mop = op; end
        else if (op == 4'd5) begin hw = 2'b01; mop = op; end
      end
    end
    stall_e = d && (busy_e || issue_e);
    expq.push_back({issue_e, mop, hw, busy_e, stall_e, done_e, abort_e, m_perr});
    cycq.push_back(cyc);
    if (r) begin
      m_act = 1'b0;
      m_perr = 1'b0;
    end else begin
      if (m_act && v && (op <= 4'd5)) m_perr = 1'b1;
      if (done_e || abort_e) m_act = 1'b0;
      if (issue_e) begin
        m_act = 1'b1;
        m_done_at = cyc + ((op <= 4'd1) ? MC : DC);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit d);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd8, d, 1'b0, 1'b0);
  endtask

  // Monitor: compares the DUT's output vector against the queued prediction
  initial begin
    logic [12:0] got, exp_v;
    int c;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        exp_v = expq.pop_front();
        c = cycq.pop_front();
        got = {mdu_start, mdu_op, hilo_we, busy, stall, done, mdu_abort, proto_err};
        vecs++;
        if (got !== exp_v) begin
          errs++;
          $display("FAIL outs cyc %0d: got start=%b op=%0d hw=%b busy=%b stall=%b done=%b abort=%b perr=%b, exp start=%b op=%0d hw=%b busy=%b stall=%b done=%b abort=%b perr=%b",
                   c, got[12], got[11:8], got[7:6], got[5], got[4], got[3], got[2], got[1],
                   exp_v[12], exp_v[11:8], exp_v[7:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1]);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    @(posedge clk);
    step(1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
    // mult latency
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    idle(7, 1'b0);
    // div with D-stage MDU use held
    step(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    idle(11, 1'b1);
    idle(1, 1'b0);
    // mthi/mtlo, then suppressed by interrupt and eret
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    // overlap while busy sets sticky proto_err
    step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    idle(10, 1'b0);
    step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    idle(7, 1'b0);
    step(1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
    // interrupt in RUN
    step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b0);
    // interrupt exactly in the commit cycle
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    // reset mid-divide, then immediate re-issue
    step(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(7, 1'b0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 1) == 1),
           4'($urandom_range(0, 8)),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 15) == 0));
    end
    idle(12, 1'b0);
    repeat (2) @(negedge clk);
    if (expq.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending, exp 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
